srec_loader: RTL
================

SREC_LOADER -- requirements
Module: srec_loader

Interface
REQ-001 SHALL have parameter ADDR_BASE, default 32'h0000_0000: subtracted from every record address before it is driven on mem_address.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  one-cycle pulse that begins a load.
REQ-005 SHALL have port rx_data  input  8  ASCII character of the SREC text stream.
REQ-006 SHALL have port rx_valid  input  1  rx_data holds a character.
REQ-007 SHALL have port rx_ready  output  1  loader accepts the character; transfer occurs when rx_valid && rx_ready.
REQ-008 SHALL have port srec_parse  output  1  loader owns the instruction-memory port.
REQ-009 SHALL have port mem_address  output  32  word write address.
REQ-010 SHALL have port mem_data_in  output  32  big-endian write data.
REQ-011 SHALL have port mem_write  output  1  one-cycle write strobe.
REQ-012 SHALL have port mem_access_size  output  2  held at 2'b00 (single word).
REQ-013 SHALL have port done  output  1  sticky; termination record accepted.
REQ-014 SHALL have port err_format  output  1  sticky; illegal character or malformed record.
REQ-015 SHALL have port err_checksum  output  1  sticky; checksum mismatch (see Configuration).
REQ-016 SHALL have port entry_addr  output  32  address field of the S7/S8/S9 record, unmodified by ADDR_BASE.

Function
REQ-017 SHALL implement states IDLE, SYNC, TYPE, COUNT, ADDR, DATA, CKSUM, DONE, ERROR.
REQ-018 IDLE: start moves to SYNC; srec_parse SHALL be high in every state except IDLE, DONE and ERROR.
REQ-019 SYNC: CR, LF and space SHALL be discarded; 'S' moves to TYPE; any other character moves to ERROR.
REQ-020 TYPE: '0'-'3', '5', '7'-'9' are accepted; address length is 2 bytes for types 0, 1, 5 and 9, 3 bytes for 2 and 8, and 4 bytes for 3 and 7; other characters move to ERROR.
REQ-021 Hex digits '0'-'9', 'A'-'F' and 'a'-'f' SHALL decode two characters per byte, high nibble first; a non-hex character in COUNT, ADDR, DATA or CKSUM moves to ERROR.
REQ-022 Data length SHALL be count - addrlen - 1; count < addrlen + 1 moves to ERROR.
REQ-023 Types 0 and 5 SHALL consume their data without writing memory.
REQ-024 Types 1, 2 and 3 SHALL pack data bytes big-endian into a word.
REQ-025 Write on full word: mem_write SHALL pulse in the cycle after the 4th byte's second nibble is accepted, with mem_address = record address - ADDR_BASE + 4*word index.
REQ-026 Partial final word (1-3 bytes): SHALL be written in the same way, with unused low bytes zero-filled.
REQ-027 rx_ready SHALL be low in the mem_write cycle and in IDLE, DONE and ERROR; it is high otherwise.
REQ-028 After CKSUM, data records SHALL return to SYNC; types 7, 8 and 9 SHALL latch entry_addr and move to DONE.
REQ-029 DONE and ERROR SHALL hold until start, which clears done, err_format, err_checksum and the record state and enters SYNC.
REQ-030 start during an active load SHALL be ignored.
REQ-031 The address SHALL wrap modulo 2^32.

Reset
REQ-032 rst_n low SHALL immediately force IDLE and drive all outputs to 0, including entry_addr, mem_address and mem_data_in.
REQ-033 Reset in the middle of a record SHALL abandon the record without any further mem_write.

Configuration
REQ-034 With SREC_CHECKSUM_EN defined, the checksum SHALL be the ones-complement of the low byte of the sum of count, address and data bytes; a mismatch sets err_checksum and moves to ERROR (writes already issued stand).
REQ-035 Without SREC_CHECKSUM_EN, the checksum byte SHALL be hex-checked and then discarded, and err_checksum SHALL be tied to 0.

Verification
REQ-036 start, then "S30900000000DEADBEEFBE\r\n" -> exactly one mem_write: address 0x0, data 0xDEADBEEF; no error.
REQ-037 "S1050010ABCD72" -> one mem_write: address 0x10, data 0xABCD0000.
REQ-038 "S9030000FC" -> done=1, entry_addr=0, srec_parse=0, rx_ready=0.
REQ-039 SREC_CHECKSUM_EN defined, "S30900000000DEADBEEF00" -> one write, then err_checksum=1; undefined -> no error.
REQ-040 "S3G..." or "X" in SYNC -> err_format=1, no mem_write; start clears the error and a following valid record loads correctly.
REQ-041 rst_n low during the DATA state of an S3 record -> all outputs 0 at once and no write strobe.

Source files
------------

// File: rtl/srec_loader.sv
// srec_loader -- streams Motorola S-record text into an instruction memory.
//
// Characters arrive on a valid/ready byte stream. S1/S2/S3 data bytes are
// packed big-endian into 32-bit words. Each full word is written to memory
// with a one-cycle strobe, and so is a final partial word, which is
// zero-filled in its low bytes. S0/S5 records are parsed but not written.
// An S7/S8/S9 record latches the entry address and finishes the load.
//
// Optional feature: define SREC_CHECKSUM_EN to verify each record checksum.
// Without it the checksum digits are only hex-checked, and err_checksum is 0.
//
// Ports
//   clk             : clock, rising edge
//   rst_n           : asynchronous active-low reset
//   start           : one-cycle pulse; begins a load from IDLE/DONE/ERROR
//   rx_data/valid   : incoming ASCII character
//   rx_ready        : loader accepts the character this cycle
//   srec_parse      : loader owns the memory port (load in progress)
//   mem_address     : word write address (record address - ADDR_BASE)
//   mem_data_in     : big-endian write data
//   mem_write       : one-cycle write strobe
//   mem_access_size : constant 2'b00 (word access)
//   done            : sticky; termination record accepted
//   err_format      : sticky; illegal character or malformed record
//   err_checksum    : sticky; checksum mismatch
//   entry_addr      : address field of the termination record
module srec_loader #(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        srec_parse,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic        mem_write,
  output logic [1:0]  mem_access_size,
  output logic        done,
  output logic        err_format,
  output logic        err_checksum,
  output logic [31:0] entry_addr
);

`ifdef SREC_CHECKSUM_EN
  localparam logic CKSUM_EN = 1'b1;
`else
  localparam logic CKSUM_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    IDLE, SYNC, TYPE, COUNT, ADDR, DATA, CKSUM, DONE, ERROR
  } state_t;

  state_t      state_reg, state_next;
  logic [3:0]  type_reg, type_next;
  logic [2:0]  addr_len_reg, addr_len_next;
  logic [7:0]  data_left_reg, data_left_next;
  logic [1:0]  byte_cnt_reg, byte_cnt_next;
  logic        nib_phase_reg, nib_phase_next;
  logic [3:0]  hi_nib_reg, hi_nib_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] wr_addr_reg, wr_addr_next;
  logic [31:0] word_reg, word_next;
  logic [1:0]  pos_reg, pos_next;
  logic [7:0]  sum_reg, sum_next;
  logic        mem_write_reg, mem_write_next;
  logic [31:0] mem_address_reg, mem_address_next;
  logic [31:0] mem_data_reg, mem_data_next;
  logic        done_reg, done_next;
  logic        err_format_reg, err_format_next;
  logic        err_cksum_reg, err_cksum_next;
  logic [31:0] entry_reg, entry_next;

  logic        hex_ok;
  logic [3:0]  hex_nib;
  logic [7:0]  byte_val;
  logic [31:0] ins_word;
  logic [31:0] full_addr;
  logic        accept;
  logic        active;
  logic        data_is_mem;
  logic        cksum_bad;

  // ASCII hex digit decode; letters map to 10..15 via their low nibble + 9.
  always_comb begin
    hex_ok  = 1'b0;
    hex_nib = 4'h0;
    if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
      hex_ok  = 1'b1;
      hex_nib = rx_data[3:0];
    end else if ((rx_data >= 8'h41 && rx_data <= 8'h46) ||
                 (rx_data >= 8'h61 && rx_data <= 8'h66)) begin
      hex_ok  = 1'b1;
      hex_nib = rx_data[3:0] + 4'd9;
    end
  end

  assign byte_val  = {hi_nib_reg, hex_nib};
  assign full_addr = {addr_reg[23:0], byte_val};

  // Byte-lane insert: position 0 is the most significant byte.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(3 - gi);
      assign ins_word[8*gi +: 8] = (pos_reg == LANE) ? byte_val : word_reg[8*gi +: 8];
    end
  endgenerate

  assign active = (state_reg != IDLE) && (state_reg != DONE) && (state_reg != ERROR);
  // No character is taken while a write strobe is on the port.
  assign rx_ready    = active && !mem_write_reg;
  assign srec_parse  = active;
  assign accept      = rx_valid && rx_ready;
  assign data_is_mem = (type_reg == 4'd1) || (type_reg == 4'd2) || (type_reg == 4'd3);
  assign cksum_bad   = CKSUM_EN && (byte_val != ~sum_reg);

  always_comb begin
    state_next       = state_reg;
    type_next        = type_reg;
    addr_len_next    = addr_len_reg;
    data_left_next   = data_left_reg;
    byte_cnt_next    = byte_cnt_reg;
    nib_phase_next   = nib_phase_reg;
    hi_nib_next      = hi_nib_reg;
    addr_next        = addr_reg;
    wr_addr_next     = wr_addr_reg;
    word_next        = word_reg;
    pos_next         = pos_reg;
    sum_next         = sum_reg;
    mem_write_next   = 1'b0;
    mem_address_next = mem_address_reg;
    mem_data_next    = mem_data_reg;
    done_next        = done_reg;
    err_format_next  = err_format_reg;
    err_cksum_next   = err_cksum_reg;
    entry_next       = entry_reg;

    case (state_reg)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_next      = SYNC;
          done_next       = 1'b0;
          err_format_next = 1'b0;
          err_cksum_next  = 1'b0;
          nib_phase_next  = 1'b0;
          pos_next        = 2'd0;
          word_next       = 32'h0;
        end
      end

      SYNC: begin
        if (accept) begin
          if (rx_data == 8'h53) begin
            state_next     = TYPE;
            nib_phase_next = 1'b0;
            sum_next       = 8'h00;
            addr_next      = 32'h0;
            byte_cnt_next  = 2'd0;
            pos_next       = 2'd0;
            word_next      = 32'h0;
          end else if (rx_data != 8'h0D && rx_data != 8'h0A && rx_data != 8'h20) begin
            state_next      = ERROR;
            err_format_next = 1'b1;
          end
        end
      end

      TYPE: begin
        if (accept) begin
          type_next  = rx_data[3:0];
          state_next = COUNT;
          case (rx_data)
            8'h30, 8'h31, 8'h35, 8'h39: addr_len_next = 3'd2;
            8'h32, 8'h38:               addr_len_next = 3'd3;
            8'h33, 8'h37:               addr_len_next = 3'd4;
            default: begin
              state_next      = ERROR;
              err_format_next = 1'b1;
            end
          endcase
        end
      end

      COUNT, ADDR, DATA, CKSUM: begin
        if (accept) begin
          if (!hex_ok) begin
            state_next      = ERROR;
            err_format_next = 1'b1;
          end else if (!nib_phase_reg) begin
            hi_nib_next    = hex_nib;
            nib_phase_next = 1'b1;
          end else begin
            nib_phase_next = 1'b0;
            case (state_reg)
              COUNT: begin
                sum_next = byte_val;
                if (byte_val < (8'(addr_len_reg) + 8'd1)) begin
                  state_next      = ERROR;
                  err_format_next = 1'b1;
                end else begin
                  data_left_next = byte_val - 8'(addr_len_reg) - 8'd1;
                  byte_cnt_next  = 2'd0;
                  state_next     = ADDR;
                end
              end
              ADDR: begin
                sum_next      = sum_reg + byte_val;
                addr_next     = full_addr;
                byte_cnt_next = byte_cnt_reg + 2'd1;
                // addr_len of 4 wraps to 0 in two bits, so minus one gives 3.
                if (byte_cnt_reg == (addr_len_reg[1:0] - 2'd1)) begin
                  wr_addr_next = full_addr - ADDR_BASE;
                  state_next   = (data_left_reg == 8'd0) ? CKSUM : DATA;
                end
              end
              DATA: begin
                sum_next       = sum_reg + byte_val;
                data_left_next = data_left_reg - 8'd1;
                if (data_is_mem) begin
                  if (pos_reg == 2'd3 || data_left_reg == 8'd1) begin
                    mem_write_next   = 1'b1;
                    mem_address_next = wr_addr_reg;
                    mem_data_next    = ins_word;
                    wr_addr_next     = wr_addr_reg + 32'd4;
                    word_next        = 32'h0;
                    pos_next         = 2'd0;
                  end else begin
                    word_next = ins_word;
                    pos_next  = pos_reg + 2'd1;
                  end
                end
                if (data_left_reg == 8'd1) state_next = CKSUM;
              end
              CKSUM: begin
                if (cksum_bad) begin
                  err_cksum_next = 1'b1;
                  state_next     = ERROR;
                end else if (type_reg == 4'd7 || type_reg == 4'd8 || type_reg == 4'd9) begin
                  entry_next = addr_reg;
                  done_next  = 1'b1;
                  state_next = DONE;
                end else begin
                  state_next = SYNC;
                end
              end
              default: ;
            endcase
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      type_reg        <= 4'h0;
      addr_len_reg    <= 3'd0;
      data_left_reg   <= 8'h00;
      byte_cnt_reg    <= 2'd0;
      nib_phase_reg   <= 1'b0;
      hi_nib_reg      <= 4'h0;
      addr_reg        <= 32'h0;
      wr_addr_reg     <= 32'h0;
      word_reg        <= 32'h0;
      pos_reg         <= 2'd0;
      sum_reg         <= 8'h00;
      mem_write_reg   <= 1'b0;
      mem_address_reg <= 32'h0;
      mem_data_reg    <= 32'h0;
      done_reg        <= 1'b0;
      err_format_reg  <= 1'b0;
      err_cksum_reg   <= 1'b0;
      entry_reg       <= 32'h0;
    end else begin
      state_reg       <= state_next;
      type_reg        <= type_next;
      addr_len_reg    <= addr_len_next;
      data_left_reg   <= data_left_next;
      byte_cnt_reg    <= byte_cnt_next;
      nib_phase_reg   <= nib_phase_next;
      hi_nib_reg      <= hi_nib_next;
      addr_reg        <= addr_next;
      wr_addr_reg     <= wr_addr_next;
      word_reg        <= word_next;
      pos_reg         <= pos_next;
      sum_reg         <= sum_next;
      mem_write_reg   <= mem_write_next;
      mem_address_reg <= mem_address_next;
      mem_data_reg    <= mem_data_next;
      done_reg        <= done_next;
      err_format_reg  <= err_format_next;
      err_cksum_reg   <= err_cksum_next;
      entry_reg       <= entry_next;
    end
  end

  assign mem_write       = mem_write_reg;
  assign mem_address     = mem_address_reg;
  assign mem_data_in     = mem_data_reg;
  assign mem_access_size = 2'b00;
  assign done            = done_reg;
  assign err_format      = err_format_reg;
  assign err_checksum    = err_cksum_reg;
  assign entry_addr      = entry_reg;

endmodule
